turn_scheduler: RTL and testbench
=================================

# turn_scheduler

Parametrised turn sequencer for the board-game controller. Generalises the fixed 2/3/4-player turn rotation to any player count up to MAX_PLAYERS, skips eliminated players, and supports reversing the direction of play. It also counts rounds and flags both the sole-survivor and no-survivor end conditions. It sits between the game FSM, which drives start, advance and reverse, and the display/score logic, which consumes cur_player, round_cnt and the status flags.

## Interface
- MAX_PLAYERS, 4, maximum seats supported; legal range 2..16
- PW, $clog2(MAX_PLAYERS), width of a seat index (derived, not overridden)
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse: latch player_cnt and begin a new game
- player_cnt  in  PW+1  number of seated players, 2..MAX_PLAYERS; sampled only on start
- advance  in  1  level from game FSM; each rising edge requests the next turn
- reverse  in  1  single-cycle pulse: toggle direction of play
- out_mask  in  MAX_PLAYERS  bit i=1 means seat i is eliminated; sampled live on every probe
- cur_player  out  PW  seat whose turn it is
- round_cnt  out  8  completed rounds, saturating at 255
- dir  out  1  0 = forward (index increasing), 1 = reverse
- turn_valid  out  1  one-cycle pulse when cur_player is committed
- busy  out  1  high while in SEEK
- sole_player  out  1  level: exactly one active seat remains (cur_player)
- all_out  out  1  level: no active seat remains
- cfg_err  out  1  one-cycle pulse: start with illegal player_cnt

## Operation
- States: IDLE, SEEK, READY, DONE.
- Reset: state IDLE; cur_player 0; round_cnt 0; dir 0; turn_valid, busy, sole_player, all_out and cfg_err all 0; internal advance delay register 0; pending-reverse flag 0.
- Step function: forward gives (i+1) mod player_cnt; reverse gives (i−1) mod player_cnt. The wrap flag is set when forward steps from player_cnt−1 to 0, or reverse steps from 0 to player_cnt−1.
- start, accepted in any state, restarts the game:
  - If player_cnt is outside 2..MAX_PLAYERS: pulse cfg_err and go to IDLE.
  - Otherwise: latch the count; clear round_cnt, dir, flags and pending reverse; set candidate = 0 with no step; probe count = 0; go to SEEK in start mode.
- In READY, a rising edge of advance (advance & ~advance_d) sets candidate = step(cur_player) and probe count = 0, and moves to SEEK.
- SEEK probes one candidate per cycle:
  - If out_mask[candidate] == 0: commit cur_player = candidate, pulse turn_valid, go to READY.
  - Else, if probe count == player_cnt−1: go to DONE and set all_out.
  - Else: candidate = step(candidate), probe count + 1.
- If a committed candidate equals the previous cur_player and the search was not in start mode: set sole_player and go to DONE instead of READY. turn_valid still pulses.
- round_cnt increments by 1, saturating, on commit of a non-start search during which any step wrapped.
- reverse:
  - In READY: toggles dir in the same cycle.
  - In SEEK: sets the pending flag; the toggle is applied on leaving SEEK, so the current search keeps its direction.
  - In IDLE or DONE: ignored.
- DONE holds all outputs until start or rst. Advance edges are ignored in IDLE, SEEK and DONE.

## Timing
- Advance edge sampled at cycle k gives SEEK at k+1. Commit is at k+j when the j-th probed seat is the first active one, so the minimum latency is 1 cycle and the maximum is player_cnt cycles.
- Start accepted at cycle k with seat 0 active gives cur_player 0 and turn_valid at k+1.
- turn_valid is high for exactly one cycle, coincident with the first cycle of the new cur_player value.
- rst asserted mid-SEEK forces the reset values immediately (asynchronously). The first advance edge counted after release is one sampled with advance_d = 0.
- A start and an advance edge in the same cycle: start wins.

## Structure
- Shared package turn_pkg holds:
  - the state enum (IDLE, SEEK, READY, DONE)
  - DIR_FWD = 0 and DIR_REV = 1
  - ROUND_W = 8
- One combinational sub-module, seat_step: inputs index, count and dir; outputs next index and wrap flag. It is shared by the start and advance paths.

## Test plan
- MAX_PLAYERS=4, start with player_cnt=3, mask 0, then 4 advance edges → cur_player 0,1,2,0,1; round_cnt 0,0,0,1,1; one turn_valid per edge.
- player_cnt=4, mask 4'b0110, cur_player 0, advance → busy for 3 cycles, cur_player 3, latency 3; next advance → 0 with round_cnt +1.
- player_cnt=4 at cur_player 2: reverse pulse in READY then advance → cur_player 1. A reverse pulse during SEEK applies only after the commit.
- player_cnt=3 at cur_player 1, mask 3'b101, advance → sole_player=1, state DONE, cur_player 1. Then set mask 3'b111 and start → all_out=1 after 3 probes.
- Start with player_cnt=1, and again with player_cnt=5 at MAX_PLAYERS=4 → cfg_err pulse and state IDLE. Assert rst mid-SEEK → all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/turn_pkg.sv
// Shared types and constants for the board-game turn sequencer.
package turn_pkg;
    typedef enum logic [1:0] {IDLE, SEEK, READY, DONE} state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;
    localparam int   ROUND_W = 8;
endpackage

// File: rtl/turn_scheduler_seat_step.sv
// Modular seat stepping: next seat in the given direction plus a wrap-around flag.
module seat_step
    import turn_pkg::*;
#(
    parameter int  MAX_PLAYERS = 4,
    localparam int PW          = $clog2(MAX_PLAYERS)
) (
    input  logic [PW-1:0] index,
    input  logic [PW:0]   count,
    input  logic          dir,
    output logic [PW-1:0] next_index,
    output logic          wrap
);
    logic [PW:0] last;

    assign last = count - 1'b1;

    always_comb begin
        next_index = '0;
        wrap       = 1'b0;
        if (dir == DIR_FWD) begin
            if ({1'b0, index} == last) wrap = 1'b1;
            else                       next_index = index + 1'b1;
        end else begin
            if (index == '0) begin
                next_index = last[PW-1:0];
                wrap       = 1'b1;
            end else begin
                next_index = index - 1'b1;
            end
        end
    end
endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: rotates through seated players, skipping eliminated seats,
// with direction reversal, round counting and end-of-game detection.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int  MAX_PLAYERS = 4,
    localparam int PW          = $clog2(MAX_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PW:0]            player_cnt,
    input  logic                   advance,
    input  logic                   reverse,
    input  logic [MAX_PLAYERS-1:0] out_mask,
    output logic [PW-1:0]          cur_player,
    output logic [ROUND_W-1:0]     round_cnt,
    output logic                   dir,
    output logic                   turn_valid,
    output logic                   busy,
    output logic                   sole_player,
    output logic                   all_out,
    output logic                   cfg_err
);
    localparam logic [PW:0] MIN_CNT = (PW+1)'(2);
    localparam logic [PW:0] MAX_CNT = (PW+1)'(MAX_PLAYERS);

    state_t        state;
    logic [PW:0]   cnt;
    logic [PW:0]   probe;
    logic [PW-1:0] cand;
    logic [PW-1:0] step_in;
    logic [PW-1:0] step_next;
    logic          step_wrap;
    logic          advance_d;
    logic          rev_pend;
    logic          start_mode;
    logic          wrapped;
    logic          adv_edge;
    logic          cnt_ok;

    assign adv_edge = advance & ~advance_d;
    assign cnt_ok   = (player_cnt >= MIN_CNT) && (player_cnt <= MAX_CNT);
    assign busy     = (state == SEEK);
    // READY steps from the committed seat, SEEK from the seat just probed.
    assign step_in  = (state == SEEK) ? cand : cur_player;

    seat_step #(.MAX_PLAYERS(MAX_PLAYERS)) u_step (
        .index      (step_in),
        .count      (cnt),
        .dir        (dir),
        .next_index (step_next),
        .wrap       (step_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_player  <= '0;
            round_cnt   <= '0;
            dir         <= DIR_FWD;
            turn_valid  <= 1'b0;
            sole_player <= 1'b0;
            all_out     <= 1'b0;
            cfg_err     <= 1'b0;
            advance_d   <= 1'b0;
            rev_pend    <= 1'b0;
            cnt         <= '0;
            probe       <= '0;
            cand        <= '0;
            start_mode  <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            advance_d  <= advance;
            turn_valid <= 1'b0;
            cfg_err    <= 1'b0;
            if (start) begin
                if (!cnt_ok) begin
                    cfg_err <= 1'b1;
                    state   <= IDLE;
                end else begin
                    cnt         <= player_cnt;
                    round_cnt   <= '0;
                    dir         <= DIR_FWD;
                    sole_player <= 1'b0;
                    all_out     <= 1'b0;
                    rev_pend    <= 1'b0;
                    cand        <= '0;
                    probe       <= '0;
                    start_mode  <= 1'b1;
                    wrapped     <= 1'b0;
                    state       <= SEEK;
                end
            end else begin
                case (state)
                    READY: begin
                        if (reverse) dir <= ~dir;
                        if (adv_edge) begin
                            cand       <= step_next;
                            probe      <= '0;
                            wrapped    <= step_wrap;
                            start_mode <= 1'b0;
                            state      <= SEEK;
                        end
                    end
                    SEEK: begin
                        if (!out_mask[cand]) begin
                            cur_player <= cand;
                            turn_valid <= 1'b1;
                            dir        <= dir ^ (rev_pend | reverse);
                            rev_pend   <= 1'b0;
                            if (!start_mode && wrapped && round_cnt != '1)
                                round_cnt <= round_cnt + ROUND_W'(1);
                            // Search came all the way back round: everyone else is out.
                            if (!start_mode && cand == cur_player) begin
                                sole_player <= 1'b1;
                                state       <= DONE;
                            end else begin
                                state <= READY;
                            end
                        end else if (probe == cnt - 1'b1) begin
                            all_out  <= 1'b1;
                            dir      <= dir ^ (rev_pend | reverse);
                            rev_pend <= 1'b0;
                            state    <= DONE;
                        end else begin
                            cand    <= step_next;
                            probe   <= probe + 1'b1;
                            wrapped <= wrapped | step_wrap;
                            if (reverse) rev_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized bench for turn_scheduler against a seat-arithmetic reference model.
module tb_turn_scheduler;
    localparam int MAXP = 4;
    localparam int PW   = $clog2(MAXP);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            advance = 1'b0;
    logic            reverse = 1'b0;
    logic [PW:0]     player_cnt = '0;
    logic [MAXP-1:0] out_mask = '0;
    logic [PW-1:0]   cur_player;
    logic [7:0]      round_cnt;
    logic            dir, turn_valid, busy, sole_player, all_out, cfg_err;

    turn_scheduler #(.MAX_PLAYERS(MAXP)) dut (
        .clk(clk), .rst(rst), .start(start), .player_cnt(player_cnt),
        .advance(advance), .reverse(reverse), .out_mask(out_mask),
        .cur_player(cur_player), .round_cnt(round_cnt), .dir(dir),
        .turn_valid(turn_valid), .busy(busy), .sole_player(sole_player),
        .all_out(all_out), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: game phase 0 idle, 1 playing, 2 over.
    int m_phase = 0;
    int m_cnt = 0, m_cur = 0, m_round = 0, m_dir = 0, m_sole = 0, m_all = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".cur"},   int'(cur_player), m_cur);
        check({tag, ".round"}, int'(round_cnt),  m_round);
        check({tag, ".dir"},   int'(dir),        m_dir);
        check({tag, ".sole"},  int'(sole_player), m_sole);
        check({tag, ".all"},   int'(all_out),    m_all);
        check({tag, ".busy"},  int'(busy),       0);
    endtask

    // Walk seats with modular arithmetic until an active one is found.
    task automatic model_search(input bit smode, output int lat, output bit hit);
        int base;
        base = smode ? 0 : m_cur;
        hit  = 1'b0;
        lat  = m_cnt;
        for (int j = 0; j < m_cnt; j++) begin
            int off, raw, s;
            off = smode ? j : j + 1;
            raw = (m_dir != 0) ? base - off : base + off;
            s   = ((raw % m_cnt) + m_cnt) % m_cnt;
            if (!out_mask[s]) begin
                hit = 1'b1;
                lat = j + 1;
                if (!smode && (raw < 0 || raw >= m_cnt) && m_round < 255) m_round++;
                m_sole  = (!smode && s == m_cur) ? 1 : 0;
                m_cur   = s;
                m_phase = (m_sole != 0) ? 2 : 1;
                break;
            end
        end
        if (!hit) begin
            m_all   = 1;
            m_phase = 2;
        end
    endtask

    task automatic wait_search(input bit smode, input bit rs, input string tag);
        int n, lat;
        bit hit, go;
        n  = 0;
        go = smode || (m_phase == 1);
        lat = 0;
        hit = 1'b0;
        if (go) model_search(smode, lat, hit);
        while (busy && n < 40) begin
            n++;
            if (n == 1 && rs) reverse = 1'b1;
            tick;
            reverse = 1'b0;
        end
        if (go && rs) m_dir ^= 1;
        check({tag, ".lat"}, n, lat);
        check({tag, ".tv"}, int'(turn_valid), (go && hit) ? 1 : 0);
        check_outs(tag);
        tick;
        check({tag, ".tv_off"}, int'(turn_valid), 0);
    endtask

    task automatic do_start(input int c, input bit rs);
        player_cnt = (PW+1)'(c);
        start = 1'b1;
        tick;
        start = 1'b0;
        if (c < 2 || c > MAXP) begin
            m_phase = 0;
            check("cfg.err", int'(cfg_err), 1);
            check("cfg.busy", int'(busy), 0);
            tick;
            check("cfg.err_off", int'(cfg_err), 0);
            check_outs("cfg");
        end else begin
            m_cnt = c; m_round = 0; m_dir = 0; m_sole = 0; m_all = 0;
            check("start.cfg", int'(cfg_err), 0);
            wait_search(1'b1, rs, "start");
        end
    endtask

    task automatic do_advance(input bit rs);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        wait_search(1'b0, rs, "adv");
    endtask

    task automatic do_reverse;
        reverse = 1'b1;
        tick;
        reverse = 1'b0;
        if (m_phase == 1) m_dir ^= 1;
        check("rev.dir", int'(dir), m_dir);
        check("rev.busy", int'(busy), 0);
    endtask

    task automatic rand_mask;
        logic [MAXP-1:0] mk;
        mk = '0;
        for (int i = 0; i < MAXP; i++) if ($urandom_range(0, 3) == 0) mk[i] = 1'b1;
        if ($urandom_range(0, 7) == 0) mk = '1;
        out_mask = mk;
    endtask

    initial begin
        #12;
        check("rst.cur", int'(cur_player), 0);
        check("rst.round", int'(round_cnt), 0);
        check("rst.dir", int'(dir), 0);
        check("rst.tv", int'(turn_valid), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.flags", int'({sole_player, all_out, cfg_err}), 0);
        rst = 1'b0;
        tick;

        // Plain rotation with three players.
        out_mask = '0;
        do_start(3, 1'b0);
        repeat (4) do_advance(1'b0);

        // Skip over eliminated seats, then wrap for a new round.
        out_mask = 4'b0110;
        do_start(4, 1'b0);
        do_advance(1'b0);
        do_advance(1'b0);

        // Reverse in READY, then reverse during a search.
        out_mask = '0;
        do_start(4, 1'b0);
        do_advance(1'b0);
        do_advance(1'b0);
        do_reverse;
        do_advance(1'b0);
        do_advance(1'b1);
        do_advance(1'b0);

        // Sole survivor, then nobody left.
        do_start(3, 1'b0);
        do_advance(1'b0);
        out_mask = 4'b0101;
        do_advance(1'b0);
        do_advance(1'b0);
        do_reverse;
        out_mask = 4'b0111;
        do_start(3, 1'b0);

        // Illegal counts.
        out_mask = '0;
        do_start(1, 1'b0);
        do_start(5, 1'b0);
        do_start(0, 1'b0);
        do_advance(1'b0);

        // Random play.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0:       do_start(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                1, 2:    rand_mask;
                3:       do_reverse;
                default: do_advance($urandom_range(0, 3) == 0);
            endcase
        end

        // Round counter saturation.
        out_mask = '0;
        do_start(2, 1'b0);
        repeat (520) do_advance(1'b0);
        check("sat.round", int'(round_cnt), 255);

        // Asynchronous reset in the middle of a search.
        out_mask = 4'b0111;
        do_start(4, 1'b0);
        out_mask = 4'b0110;
        advance = 1'b1;
        tick;
        advance = 1'b0;
        check("arst.pre_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        m_phase = 0; m_cur = 0; m_round = 0; m_dir = 0; m_sole = 0; m_all = 0;
        check("arst.tv", int'(turn_valid), 0);
        check("arst.cfg", int'(cfg_err), 0);
        check_outs("arst");
        #2 rst = 1'b0;
        tick;
        do_advance(1'b0);
        out_mask = '0;
        do_start(3, 1'b0);
        do_advance(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
